// File: rtl/filtro_andar.sv
// Floor reading filter for the HC-SR04 lift sensor interface.
// Accepts a floor only after CONSEC identical consecutive readings, flags a
// sensor timeout when pronto pulses stop arriving, and reports arrival at the
// requested floor.
//
// Ports:
//   clock, reset   system clock (rising edge), asynchronous active-high reset
//   ligado         enable; 0 returns the filter to INICIAL on the next edge
//   pronto, andar  one-cycle valid pulse and raw 2-bit floor reading
//   andar_destino  floor requested by the lift controller
//   andar_atual    last accepted floor (registered)
//   valido         andar_atual is trustworthy (registered)
//   mudou          one-cycle pulse while andar_atual is being updated (registered)
//   chegou         valido && andar_atual == andar_destino (combinational)
//   erro_sensor    pronto timeout; held until next pronto or ligado=0 (registered)
//   db_estado      state code for the debug display
module filtro_andar #(
    parameter int unsigned CONSEC  = 3,
    parameter int unsigned TIMEOUT = 5000000,
    parameter int unsigned TW      = 23
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligado,
    input  logic       pronto,
    input  logic [1:0] andar,
    input  logic [1:0] andar_destino,
    output logic [1:0] andar_atual,
    output logic       valido,
    output logic       mudou,
    output logic       chegou,
    output logic       erro_sensor,
    output logic [3:0] db_estado
);

    localparam int unsigned CW = 4;
    localparam logic [TW-1:0] TIMER_LIM = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CONT_MAX  = CW'(CONSEC);

    typedef enum logic [3:0] {
        INICIAL  = 4'h0,
        ESPERA   = 4'h1,
        COMPARA  = 4'h2,
        ATUALIZA = 4'h3,
        ERRO     = 4'hE
    } estado_t;

    estado_t         estado;
    estado_t         estado_prox;
    logic            amostra;
    logic [1:0]      candidato;
    logic [CW-1:0]   cont_igual;
    logic [TW-1:0]   timer;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= estado_prox;
        end
    end

    // Next-state logic; amostra marks a pronto that is actually consumed
    always_comb begin
        estado_prox = estado;
        amostra     = 1'b0;
        unique case (estado)
            INICIAL: begin
                estado_prox = ESPERA;
            end
            ESPERA: begin
                // pronto takes priority over a timeout on the same cycle
                if (pronto) begin
                    amostra     = 1'b1;
                    estado_prox = COMPARA;
                end else if (timer == TIMER_LIM) begin
                    estado_prox = ERRO;
                end
            end
            COMPARA: begin
                if ((cont_igual == CONT_MAX) && (!valido || (candidato != andar_atual))) begin
                    estado_prox = ATUALIZA;
                end else begin
                    estado_prox = ESPERA;
                end
            end
            ATUALIZA: begin
                estado_prox = ESPERA;
            end
            ERRO: begin
                if (pronto) begin
                    amostra     = 1'b1;
                    estado_prox = COMPARA;
                end
            end
            default: begin
                estado_prox = INICIAL;
            end
        endcase
        if (!ligado) begin
            estado_prox = INICIAL;
            amostra     = 1'b0;
        end
    end

    // Datapath: candidate tracking, timeout counter and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            andar_atual <= 2'd0;
            valido      <= 1'b0;
            mudou       <= 1'b0;
            erro_sensor <= 1'b0;
            candidato   <= 2'd0;
            cont_igual  <= '0;
            timer       <= '0;
        end else begin
            mudou       <= (estado_prox == ATUALIZA);
            erro_sensor <= (estado_prox == ERRO);
            if (estado_prox == INICIAL) begin
                // andar_atual and candidato are kept across a disable
                timer      <= '0;
                cont_igual <= '0;
                valido     <= 1'b0;
            end else if (estado_prox == ERRO) begin
                // force CONSEC fresh readings before trusting the floor again
                valido     <= 1'b0;
                cont_igual <= '0;
            end else if (amostra) begin
                timer <= '0;
                if (andar == candidato) begin
                    cont_igual <= (cont_igual >= CONT_MAX) ? CONT_MAX : cont_igual + CW'(1);
                end else begin
                    candidato  <= andar;
                    cont_igual <= CW'(1);
                end
            end else if (estado == ATUALIZA) begin
                andar_atual <= candidato;
                valido      <= 1'b1;
            end else if ((estado == ESPERA) && (timer != TIMER_LIM)) begin
                timer <= timer + TW'(1);
            end
        end
    end

    assign chegou    = valido && (andar_atual == andar_destino);
    assign db_estado = estado;

endmodule

// File: tb/tb_filtro_andar.sv
// Directed self-checking bench for filtro_andar (CONSEC=3, TIMEOUT=20).
module tb_filtro_andar;

    logic       clock;
    logic       reset;
    logic       ligado;
    logic       pronto;
    logic [1:0] andar;
    logic [1:0] andar_destino;
    logic [1:0] andar_atual;
    logic       valido;
    logic       mudou;
    logic       chegou;
    logic       erro_sensor;
    logic [3:0] db_estado;

    int total;
    int bad;
    int mudou_cnt;

    filtro_andar #(
        .CONSEC (3),
        .TIMEOUT(20),
        .TW     (5)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ligado       (ligado),
        .pronto       (pronto),
        .andar        (andar),
        .andar_destino(andar_destino),
        .andar_atual  (andar_atual),
        .valido       (valido),
        .mudou        (mudou),
        .chegou       (chegou),
        .erro_sensor  (erro_sensor),
        .db_estado    (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (mudou) mudou_cnt++;
    end

    // One pronto pulse; returns db_estado on the three following negedges
    task automatic send(input logic [1:0] v, output logic [3:0] s1, output logic [3:0] s2,
                        output logic [3:0] s3);
        @(negedge clock);
        pronto = 1'b1;
        andar  = v;
        @(negedge clock);
        pronto = 1'b0;
        s1 = db_estado;
        @(negedge clock);
        s2 = db_estado;
        @(negedge clock);
        s3 = db_estado;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ligado = 1'b0;
        pronto = 1'b0;
        andar = 2'd0;
        andar_destino = 2'd0;
        #12;
        total++;
        if ({andar_atual, valido, mudou, chegou, erro_sensor, db_estado} !== 10'd0) begin
            bad++;
            $display("FAIL reset_outputs got atual=%0d valido=%0b mudou=%0b chegou=%0b erro=%0b db=%0h want all 0",
                     andar_atual, valido, mudou, chegou, erro_sensor, db_estado);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_accept();
        logic [3:0] s1, s2, s3;
        int m0;
        @(negedge clock);
        ligado = 1'b1;
        @(negedge clock);
        total++;
        if (db_estado !== 4'h1) begin
            bad++;
            $display("FAIL enter_espera got %0h want 1", db_estado);
        end
        m0 = mudou_cnt;
        send(2'd2, s1, s2, s3);
        send(2'd2, s1, s2, s3);
        total++;
        if (valido !== 1'b0 || mudou_cnt != m0) begin
            bad++;
            $display("FAIL accept_early got valido=%0b mudou=%0d want 0 0", valido, mudou_cnt - m0);
        end
        send(2'd2, s1, s2, s3);
        total++;
        if ({s1, s2, s3} !== 12'h231) begin
            bad++;
            $display("FAIL accept_states got %0h,%0h,%0h want 2,3,1", s1, s2, s3);
        end
        total++;
        if (andar_atual !== 2'd2 || valido !== 1'b1 || mudou_cnt != m0 + 1) begin
            bad++;
            $display("FAIL accept_floor got atual=%0d valido=%0b mudou=%0d want 2 1 1",
                     andar_atual, valido, mudou_cnt - m0);
        end
        // Fourth identical reading: counter saturated, floor unchanged, no pulse
        send(2'd2, s1, s2, s3);
        total++;
        if (s2 !== 4'h1 || mudou_cnt != m0 + 1) begin
            bad++;
            $display("FAIL accept_repeat got s2=%0h mudou=%0d want 1 1", s2, mudou_cnt - m0);
        end
    endtask

    task automatic test_outlier();
        logic [3:0] s1, s2, s3;
        int m0;
        m0 = mudou_cnt;
        send(2'd1, s1, s2, s3);
        send(2'd2, s1, s2, s3);
        send(2'd1, s1, s2, s3);
        send(2'd1, s1, s2, s3);
        total++;
        if (andar_atual !== 2'd2 || valido !== 1'b1 || mudou_cnt != m0) begin
            bad++;
            $display("FAIL outlier_hold got atual=%0d valido=%0b mudou=%0d want 2 1 0",
                     andar_atual, valido, mudou_cnt - m0);
        end
        send(2'd1, s1, s2, s3);
        total++;
        if (andar_atual !== 2'd1 || valido !== 1'b1 || mudou_cnt != m0 + 1) begin
            bad++;
            $display("FAIL outlier_change got atual=%0d valido=%0b mudou=%0d want 1 1 1",
                     andar_atual, valido, mudou_cnt - m0);
        end
    endtask

    task automatic test_chegou();
        @(negedge clock);
        andar_destino = 2'd1;
        #1;
        total++;
        if (chegou !== 1'b1) begin
            bad++;
            $display("FAIL chegou_match got %0b want 1", chegou);
        end
        andar_destino = 2'd3;
        #1;
        total++;
        if (chegou !== 1'b0) begin
            bad++;
            $display("FAIL chegou_miss got %0b want 0", chegou);
        end
    endtask

    task automatic test_timeout();
        logic [3:0] s1, s2, s3;
        int n;
        int m0;
        andar_destino = 2'd1;
        send(2'd1, s1, s2, s3);
        // Pronto lands on the very cycle the timer reaches TIMEOUT-1
        repeat (17) @(negedge clock);
        send(2'd1, s1, s2, s3);
        total++;
        if (s1 !== 4'h2 || erro_sensor !== 1'b0) begin
            bad++;
            $display("FAIL timeout_edge_pronto got db=%0h erro=%0b want 2 0", s1, erro_sensor);
        end
        n = 0;
        while (erro_sensor !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        total++;
        if (n != 19) begin
            bad++;
            $display("FAIL timeout_cycles got %0d want 19", n);
        end
        total++;
        if (valido !== 1'b0 || chegou !== 1'b0 || db_estado !== 4'hE) begin
            bad++;
            $display("FAIL timeout_state got valido=%0b chegou=%0b db=%0h want 0 0 E",
                     valido, chegou, db_estado);
        end
        m0 = mudou_cnt;
        send(2'd3, s1, s2, s3);
        total++;
        if (s1 !== 4'h2 || erro_sensor !== 1'b0 || valido !== 1'b0) begin
            bad++;
            $display("FAIL recover_first got db=%0h erro=%0b valido=%0b want 2 0 0",
                     s1, erro_sensor, valido);
        end
        send(2'd3, s1, s2, s3);
        send(2'd3, s1, s2, s3);
        total++;
        if (andar_atual !== 2'd3 || valido !== 1'b1 || mudou_cnt != m0 + 1) begin
            bad++;
            $display("FAIL recover_floor got atual=%0d valido=%0b mudou=%0d want 3 1 1",
                     andar_atual, valido, mudou_cnt - m0);
        end
    endtask

    task automatic test_disable();
        logic [3:0] s1, s2, s3;
        int m0;
        m0 = mudou_cnt;
        send(2'd0, s1, s2, s3);
        send(2'd0, s1, s2, s3);
        @(negedge clock);
        ligado = 1'b0;
        @(negedge clock);
        total++;
        if (db_estado !== 4'h0 || valido !== 1'b0 || andar_atual !== 2'd3 || erro_sensor !== 1'b0) begin
            bad++;
            $display("FAIL disable_state got db=%0h valido=%0b atual=%0d erro=%0b want 0 0 3 0",
                     db_estado, valido, andar_atual, erro_sensor);
        end
        ligado = 1'b1;
        @(negedge clock);
        send(2'd0, s1, s2, s3);
        send(2'd0, s1, s2, s3);
        total++;
        if (valido !== 1'b0 || mudou_cnt != m0) begin
            bad++;
            $display("FAIL reenable_fresh got valido=%0b mudou=%0d want 0 0", valido, mudou_cnt - m0);
        end
        send(2'd0, s1, s2, s3);
        total++;
        if (andar_atual !== 2'd0 || valido !== 1'b1 || mudou_cnt != m0 + 1) begin
            bad++;
            $display("FAIL reenable_floor got atual=%0d valido=%0b mudou=%0d want 0 1 1",
                     andar_atual, valido, mudou_cnt - m0);
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] s1, s2, s3;
        andar_destino = 2'd0;
        send(2'd2, s1, s2, s3);
        send(2'd2, s1, s2, s3);
        @(negedge clock);
        pronto = 1'b1;
        andar  = 2'd2;
        @(negedge clock);
        pronto = 1'b0;
        @(negedge clock);
        total++;
        if (db_estado !== 4'h3 || mudou !== 1'b1 || chegou !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset got db=%0h mudou=%0b chegou=%0b want 3 1 1", db_estado, mudou, chegou);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({andar_atual, valido, mudou, chegou, erro_sensor, db_estado} !== 10'd0) begin
            bad++;
            $display("FAIL async_reset got atual=%0d valido=%0b mudou=%0b chegou=%0b erro=%0b db=%0h want all 0",
                     andar_atual, valido, mudou, chegou, erro_sensor, db_estado);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        mudou_cnt = 0;
        test_reset();
        test_accept();
        test_outlier();
        test_chegou();
        test_timeout();
        test_disable();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
